// File: rtl/clock_step_controller_if.sv
// rtl/clock_step_controller_if.sv - step controller control/status signal bundle
interface clock_step_controller_if #(
    parameter int CntWidth = 16
);
    logic                Tick;
    logic                RunReq;
    logic                StepBtn;
    logic                BrkEn;
    logic [31:0]         BrkAddr;
    logic [31:0]         PC;
    logic                CpuEn;
    logic                Halted;
    logic                BrkHit;
    logic [CntWidth-1:0] StepCnt;

    modport master (
        output Tick, RunReq, StepBtn, BrkEn, BrkAddr, PC,
        input  CpuEn, Halted, BrkHit, StepCnt
    );

    modport slave (
        input  Tick, RunReq, StepBtn, BrkEn, BrkAddr, PC,
        output CpuEn, Halted, BrkHit, StepCnt
    );
endinterface

// File: rtl/clock_step_controller.sv
// rtl/clock_step_controller.sv - run/single-step/breakpoint processor clock-enable controller
module clock_step_controller #(
    parameter int DebounceCycles = 4,
    parameter int CntWidth       = 16
) (
    input logic                     Clk,
    input logic                     Rst,
    clock_step_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        Halt     = 2'd0,
        Run      = 2'd1,
        StepWait = 2'd2,
        Brk      = 2'd3
    } stateT;

    localparam logic [7:0] DbLast = 8'(DebounceCycles - 1);

    stateT               state;
    stateT               nextState;
    logic                stepFromBrk;
    logic                nextStepFromBrk;
    logic [7:0]          dbCnt;
    logic                dbLevel;
    logic                stepReq;
    logic                brkMatch;
    logic                issue;
    logic                cpuEnQ;
    logic                haltedQ;
    logic                brkHitQ;
    logic [CntWidth-1:0] stepCntQ;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dbCnt   <= 8'd0;
            dbLevel <= 1'b0;
        end else if (bus.StepBtn == dbLevel) begin
            dbCnt <= 8'd0;
        end else if (dbCnt == DbLast) begin
            dbLevel <= ~dbLevel;
            dbCnt   <= 8'd0;
        end else begin
            dbCnt <= dbCnt + 8'd1;
        end
    end

    // Press is recognised in the same cycle the debounced level rises, so held buttons never repeat.
    assign stepReq  = bus.StepBtn && !dbLevel && (dbCnt == DbLast);
    assign brkMatch = bus.BrkEn && (bus.PC == bus.BrkAddr);

    always_comb begin
        nextState       = state;
        nextStepFromBrk = stepFromBrk;
        issue           = 1'b0;
        case (state)
            Halt: begin
                if (bus.RunReq) begin
                    nextState = Run;
                end else if (stepReq) begin
                    nextState       = StepWait;
                    nextStepFromBrk = 1'b0;
                end
            end
            Run: begin
                if (!bus.RunReq) begin
                    nextState = Halt;
                end else if (bus.Tick) begin
                    if (brkMatch) begin
                        nextState = Brk;
                    end else begin
                        // Back-to-back ticks must not produce back-to-back enables.
                        issue = !cpuEnQ;
                    end
                end
            end
            StepWait: begin
                if (bus.Tick && !cpuEnQ) begin
                    issue     = 1'b1;
                    nextState = stepFromBrk ? Brk : Halt;
                end
            end
            Brk: begin
                if (stepReq) begin
                    nextState       = StepWait;
                    nextStepFromBrk = 1'b1;
                end else if (!bus.RunReq) begin
                    nextState = Halt;
                end
            end
            default: nextState = Halt;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= Halt;
            stepFromBrk <= 1'b0;
            cpuEnQ      <= 1'b0;
            haltedQ     <= 1'b1;
            brkHitQ     <= 1'b0;
            stepCntQ    <= '0;
        end else begin
            state       <= nextState;
            stepFromBrk <= nextStepFromBrk;
            cpuEnQ      <= issue;
            haltedQ     <= (nextState == Halt) || (nextState == Brk);
            brkHitQ     <= (nextState == Brk);
            if (issue) begin
                stepCntQ <= stepCntQ + CntWidth'(1);
            end
        end
    end

    assign bus.CpuEn   = cpuEnQ;
    assign bus.Halted  = haltedQ;
    assign bus.BrkHit  = brkHitQ;
    assign bus.StepCnt = stepCntQ;
endmodule
